// File: rtl/decoder_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_scan_pkg
//  Brief    : Shared defaults, FSM state type and select type for the
//             decoder address-scan sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package decoder_scan_pkg;

    localparam int SEL_W_DEF   = 3;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    typedef logic [SEL_W_DEF-1:0] sel_t;

endpackage : decoder_scan_pkg
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module   : dwell_timer
//  Brief    : Clearable up-counter that flags when the count equals the
//             supplied terminal value (the latched dwell).
//  Revision : 1.0  initial release
// ============================================================================
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic [W-1:0] load_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: restart from zero on clear, otherwise count up
    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clear_i) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count is decoded from registers only
    assign tc_o = (cnt_q == load_i);

endmodule : dwell_timer
`default_nettype wire

// File: rtl/decoder_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_scan_seq
//  Brief    : Drives the 3-to-8 decoder select with a programmable address
//             scan from first to last (wrapping past the top index), holding
//             each index dwell+1 cycles, with start/done handshake and abort.
//  Options  : DECODER_SCAN_CONT_EN adds cont_i (continuous re-scan) and
//             wrap_o (pulse on each reload of the first index).
//  Revision : 1.0  initial release
// ============================================================================
module decoder_scan_seq
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [SEL_W-1:0]   first_i,
    input  logic [SEL_W-1:0]   last_i,
    input  logic [DWELL_W-1:0] dwell_i,
`ifdef DECODER_SCAN_CONT_EN
    input  logic               cont_i,
    output logic               wrap_o,
`endif
    output logic [SEL_W-1:0]   sel_o,
    output logic               busy_o,
    output logic               step_o,
    output logic               done_o
);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [SEL_W-1:0]   first_q, first_d;
    logic [SEL_W-1:0]   last_q,  last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               cont_q,  cont_d;
    logic               step_q,  step_d;
    logic               done_q,  done_d;
    logic               wrap_q,  wrap_d;

    logic               w_tc;
    logic               w_clr;
    logic               w_accept;
    logic               w_at_last;
    logic               w_cont_in;

`ifdef DECODER_SCAN_CONT_EN
    assign w_cont_in = cont_i;
`else
    assign w_cont_in = 1'b0;
`endif

    assign w_accept  = (state_q == ST_IDLE) && start_i && !stop_i;
    assign w_at_last = (sel_q == last_q);

    dwell_timer #(
        .W (DWELL_W)
    ) u_dwell_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (w_clr),
        .load_i  (dwell_q),
        .tc_o    (w_tc)
    );

    // State, index, latched configuration and output pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            first_q <= first_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            step_q  <= step_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next state and next index; stop takes priority over completion
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        first_d = first_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        cont_d  = cont_q;
        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    state_d = ST_SCAN;
                    sel_d   = first_i;
                    first_d = first_i;
                    last_d  = last_i;
                    dwell_d = dwell_i;
                    cont_d  = w_cont_in;
                end
            end
            ST_SCAN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (w_tc) begin
                    if (!w_at_last) begin
                        // Modulo-2^SEL_W increment gives the top-to-zero wrap
                        sel_d = sel_q + SEL_W'(1);
                    end else if (cont_q) begin
                        sel_d = first_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output pulses and dwell-timer clear
    always_comb begin
        step_d = 1'b0;
        done_d = 1'b0;
        wrap_d = 1'b0;
        w_clr  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                step_d = w_accept;
            end
            ST_SCAN: begin
                if (!stop_i) begin
                    w_clr = w_tc;
                    if (w_tc) begin
                        if (!w_at_last) begin
                            step_d = 1'b1;
                        end else if (cont_q) begin
                            step_d = 1'b1;
                            wrap_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign sel_o  = sel_q;
    assign busy_o = (state_q == ST_SCAN);
    assign step_o = step_q;
    assign done_o = done_q;
`ifdef DECODER_SCAN_CONT_EN
    assign wrap_o = wrap_q;
`endif

endmodule : decoder_scan_seq
`default_nettype wire

// File: tb/tb_decoder_scan_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_scan_seq
//  Brief    : Directed self-checking bench for decoder_scan_seq. Observed
//             word is {sel, busy, step, done}; expected words are written
//             out by hand per scenario.
//  Options  : DECODER_SCAN_CONT_EN enables the continuous-scan scenario.
//  Revision : 1.0  initial release
// ============================================================================
module tb_decoder_scan_seq;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       stop_i;
    logic [2:0] first_i;
    logic [2:0] last_i;
    logic [7:0] dwell_i;
    logic [2:0] sel_o;
    logic       busy_o;
    logic       step_o;
    logic       done_o;
`ifdef DECODER_SCAN_CONT_EN
    logic       cont_i;
    logic       wrap_o;
`endif

    int n_checks;
    int n_fail;

    logic [5:0] obs;
    assign obs = {sel_o, busy_o, step_o, done_o};

    decoder_scan_seq #(
        .SEL_W   (3),
        .DWELL_W (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start_i),
        .stop_i  (stop_i),
        .first_i (first_i),
        .last_i  (last_i),
        .dwell_i (dwell_i),
`ifdef DECODER_SCAN_CONT_EN
        .cont_i  (cont_i),
        .wrap_o  (wrap_o),
`endif
        .sel_o   (sel_o),
        .busy_o  (busy_o),
        .step_o  (step_o),
        .done_o  (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start; returns just after the accepting edge (k=0)
    task automatic launch(input logic [2:0] f, input logic [2:0] l, input logic [7:0] d);
        first_i = f;
        last_i  = l;
        dwell_i = d;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (obs !== 6'b000_000) begin
            n_fail++;
            $display("FAIL reset: got %b expected %b", obs, 6'b000_000);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs !== 6'b000_000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b expected %b", obs, 6'b000_000);
        end
    endtask

    task automatic test_basic_scan();
        logic [5:0] exp;
        launch(3'd0, 3'd7, 8'd0);
        for (int k = 0; k < 8; k++) begin
            exp = {k[2:0], 3'b110};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL basic k=%0d: got %b expected %b", k, obs, exp);
            end
            tick();
        end
        n_checks++;
        if (obs !== 6'b111_001) begin
            n_fail++;
            $display("FAIL basic_done: got %b expected %b", obs, 6'b111_001);
        end
        tick();
        n_checks++;
        if (obs !== 6'b111_000) begin
            n_fail++;
            $display("FAIL basic_after: got %b expected %b", obs, 6'b111_000);
        end
    endtask

    task automatic test_dwell_wrap();
        logic [2:0] exp_sel [12] = '{3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7,
                                     3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
        logic       exp_stp [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                     1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [5:0] exp;
        launch(3'd6, 3'd1, 8'd2);
        for (int k = 0; k < 12; k++) begin
            exp = {exp_sel[k], 1'b1, exp_stp[k], 1'b0};
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL wrap k=%0d: got %b expected %b", k, obs, exp);
            end
            tick();
        end
        n_checks++;
        if (obs !== 6'b001_001) begin
            n_fail++;
            $display("FAIL wrap_done: got %b expected %b", obs, 6'b001_001);
        end
        tick();
    endtask

    task automatic test_single_index();
        int steps;
        int dones;
        int busy_cnt;
        steps    = 0;
        dones    = 0;
        busy_cnt = 0;
        launch(3'd4, 3'd4, 8'd5);
        for (int k = 0; k < 10; k++) begin
            if (step_o) steps++;
            if (done_o) dones++;
            if (busy_o) busy_cnt++;
            if (sel_o !== 3'd4) steps = 99;
            tick();
        end
        n_checks++;
        if (busy_cnt !== 6 || steps !== 1 || dones !== 1) begin
            n_fail++;
            $display("FAIL single: got busy=%0d step=%0d done=%0d expected busy=6 step=1 done=1",
                     busy_cnt, steps, dones);
        end
    endtask

    task automatic test_abort();
        launch(3'd1, 3'd6, 8'd1);
        // k=0
        n_checks++;
        if (obs !== 6'b001_110) begin
            n_fail++;
            $display("FAIL abort_k0: got %b expected %b", obs, 6'b001_110);
        end
        // start and new config during SCAN must be ignored
        start_i = 1'b1;
        first_i = 3'd5;
        last_i  = 3'd5;
        dwell_i = 8'd0;
        tick(); // k=1
        tick(); // k=2
        n_checks++;
        if (obs !== 6'b010_110) begin
            n_fail++;
            $display("FAIL abort_ignore_start: got %b expected %b", obs, 6'b010_110);
        end
        start_i = 1'b0;
        tick(); // k=3, fourth busy cycle
        n_checks++;
        if (obs !== 6'b010_100) begin
            n_fail++;
            $display("FAIL abort_k3: got %b expected %b", obs, 6'b010_100);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        n_checks++;
        if (obs !== 6'b010_000) begin
            n_fail++;
            $display("FAIL abort_stop: got %b expected %b", obs, 6'b010_000);
        end
        tick();
        tick();
        n_checks++;
        if (obs !== 6'b010_000) begin
            n_fail++;
            $display("FAIL abort_after: got %b expected %b", obs, 6'b010_000);
        end
    endtask

    task automatic test_start_stop_idle();
        first_i = 3'd3;
        last_i  = 3'd3;
        dwell_i = 8'd0;
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        n_checks++;
        if (obs !== 6'b010_000) begin
            n_fail++;
            $display("FAIL start_with_stop: got %b expected %b", obs, 6'b010_000);
        end
    endtask

    task automatic test_stop_at_last();
        launch(3'd3, 3'd3, 8'd1);
        tick(); // k=1: final cycle of the only index
        n_checks++;
        if (obs !== 6'b011_100) begin
            n_fail++;
            $display("FAIL stoplast_k1: got %b expected %b", obs, 6'b011_100);
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        n_checks++;
        if (obs !== 6'b011_000) begin
            n_fail++;
            $display("FAIL stoplast_nodone: got %b expected %b", obs, 6'b011_000);
        end
    endtask

    task automatic test_reset_mid_scan();
        int bad;
        bad = 0;
        launch(3'd2, 3'd5, 8'd3);
        for (int k = 0; k < 5; k++) tick(); // now at k=5, sel=3
        n_checks++;
        if (obs !== 6'b011_100) begin
            n_fail++;
            $display("FAIL rstmid_pre: got %b expected %b", obs, 6'b011_100);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (obs !== 6'b000_000) begin
            n_fail++;
            $display("FAIL rstmid: got %b expected %b", obs, 6'b000_000);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (busy_o || step_o || done_o) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got %0d active cycles expected 0", bad);
        end
    endtask

`ifdef DECODER_SCAN_CONT_EN
    task automatic test_cont();
        logic [2:0] exp_sel [6] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd3, 3'd4};
        logic       exp_wrp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [6:0] exp;
        cont_i = 1'b1;
        launch(3'd3, 3'd4, 8'd0);
        cont_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            exp = {exp_sel[k], 1'b1, 1'b1, 1'b0, exp_wrp[k]};
            n_checks++;
            if ({obs, wrap_o} !== exp) begin
                n_fail++;
                $display("FAIL cont k=%0d: got %b expected %b", k, {obs, wrap_o}, exp);
            end
            if (k < 5) tick();
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        n_checks++;
        if ({obs, wrap_o} !== 7'b100_0000) begin
            n_fail++;
            $display("FAIL cont_stop: got %b expected %b", {obs, wrap_o}, 7'b100_0000);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        first_i  = '0;
        last_i   = '0;
        dwell_i  = '0;
`ifdef DECODER_SCAN_CONT_EN
        cont_i   = 1'b0;
`endif
        test_reset();
        test_basic_scan();
        test_dwell_wrap();
        test_single_index();
        test_abort();
        test_start_stop_idle();
        test_stop_at_last();
        test_reset_mid_scan();
`ifdef DECODER_SCAN_CONT_EN
        test_cont();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_decoder_scan_seq
`default_nettype wire
